// File: rtl/fir_mac_scheduler_pkg.sv
// Shared types and defaults for the two-channel FIR MAC scheduler.
package fir_sched_pkg;

    localparam int unsigned NTapsDefault = 32;
    localparam int unsigned TapWDefault  = 5;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StMac,
        StDone
    } state_e;

    typedef logic [0:0] ch_idx_t;

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// Sample-strobe inputs and MAC datapath control outputs of the scheduler.
interface fir_mac_scheduler_if #(
    parameter int unsigned TAP_W = fir_sched_pkg::TapWDefault
);
    import fir_sched_pkg::*;

    logic             sample0;
    logic             sample1;
    logic             ovr_clr;
    ch_idx_t          ch_sel;
    logic             shift_en0;
    logic             shift_en1;
    logic             acc_clr;
    logic             acc_en;
    logic [TAP_W-1:0] tap_idx;
    logic             oe0;
    logic             oe1;
    logic             busy;
    logic             ovr0;
    logic             ovr1;

    modport master (
        output sample0, sample1, ovr_clr,
        input  ch_sel, shift_en0, shift_en1, acc_clr, acc_en, tap_idx,
        input  oe0, oe1, busy, ovr0, ovr1
    );

    modport slave (
        input  sample0, sample1, ovr_clr,
        output ch_sel, shift_en0, shift_en1, acc_clr, acc_en, tap_idx,
        output oe0, oe1, busy, ovr0, ovr1
    );

endinterface

// File: rtl/fir_mac_scheduler_tap_counter.sv
// Tap index counter: counts 0..NTAPS-1 while enabled, wrapping at terminal count.
module fir_tap_counter
    import fir_sched_pkg::*;
#(
    parameter int unsigned NTAPS = NTapsDefault,
    parameter int unsigned TAP_W = TapWDefault
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [TAP_W-1:0] count_o,
    output logic             tc_o
);

    localparam logic [TAP_W-1:0] LastIdx = TAP_W'(NTAPS - 1);

    logic [TAP_W-1:0] count_q, count_d;

    assign count_o = count_q;
    assign tc_o    = (count_q == LastIdx);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Shares one MAC between two FIR channels: round-robin grant, per-channel
// pending/overrun tracking and a SHIFT -> MAC x NTAPS -> DONE service sequence.
module fir_mac_scheduler
    import fir_sched_pkg::*;
#(
    parameter int unsigned NTAPS = NTapsDefault,
    parameter int unsigned TAP_W = TapWDefault
) (
    input  logic                 clk,
    input  logic                 reset,
    fir_mac_scheduler_if.slave   bus
);

    state_e     state_q, state_d;
    logic [1:0] pend_q, pend_d;
    logic [1:0] ovr_q, ovr_d;
    ch_idx_t    last_q, last_d;
    ch_idx_t    ch_q, ch_d;

    logic [1:0] sample;
    logic [1:0] req;
    logic [1:0] grant;
    ch_idx_t    gnt_ch;
    logic       cnt_en;
    logic       cnt_clr;
    logic       cnt_tc;
    logic [TAP_W-1:0] cnt;

    // A strobe arriving this cycle is already eligible for the grant at this edge.
    assign sample = {bus.sample1, bus.sample0};
    assign req    = pend_q | sample;

    assign cnt_en  = (state_q == StMac);
    assign cnt_clr = (state_q == StShift);

    fir_tap_counter #(
        .NTAPS (NTAPS),
        .TAP_W (TAP_W)
    ) u_tap_counter (
        .clk     (clk),
        .reset   (reset),
        .en_i    (cnt_en),
        .clr_i   (cnt_clr),
        .count_o (cnt),
        .tc_o    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q & ~{2{bus.ovr_clr}};
        last_d  = last_q;
        ch_d    = ch_q;
        grant   = '0;
        gnt_ch  = (req[0] && req[1]) ? ~last_q : ch_idx_t'(req[1]);

        unique case (state_q)
            StIdle, StDone: begin
                if (|req) begin
                    state_d        = StShift;
                    ch_d           = gnt_ch;
                    last_d         = gnt_ch;
                    grant[gnt_ch]  = 1'b1;
                end else begin
                    state_d = StIdle;
                    ch_d    = '0;
                end
            end
            StShift: state_d = StMac;
            StMac: begin
                if (cnt_tc) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        // Granted: consume the request but keep a same-edge strobe as new pending.
        for (int i = 0; i < 2; i++) begin
            if (grant[i]) begin
                pend_d[i] = pend_q[i] & sample[i];
            end else if (sample[i]) begin
                pend_d[i] = 1'b1;
                ovr_d[i]  = ovr_d[i] | pend_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pend_q  <= '0;
            ovr_q   <= '0;
            last_q  <= 1'b1;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.ch_sel    = ch_q;
    assign bus.shift_en0 = (state_q == StShift) && (ch_q == 1'b0);
    assign bus.shift_en1 = (state_q == StShift) && (ch_q == 1'b1);
    assign bus.acc_clr   = (state_q == StShift);
    assign bus.acc_en    = (state_q == StMac);
    assign bus.tap_idx   = cnt;
    assign bus.oe0       = (state_q == StDone) && (ch_q == 1'b0);
    assign bus.oe1       = (state_q == StDone) && (ch_q == 1'b1);
    assign bus.ovr0      = ovr_q[0];
    assign bus.ovr1      = ovr_q[1];

endmodule

// File: doc/fir_mac_scheduler.md
FIR_MAC_SCHEDULER -- requirements
Module: fir_mac_scheduler

Interface
REQ-001 Parameter NTAPS, default 32: taps per output sample, the MAC cycles per service.
REQ-002 Parameter TAP_W, default 5: width of tap index, clog2(NTAPS).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 sample0  input  1  channel-0 sample strobe, one cycle per new input sample.
REQ-006 sample1  input  1  channel-1 sample strobe, same semantics.
REQ-007 ovr_clr  input  1  clears both sticky overrun flags.
REQ-008 ch_sel  output  1  channel owning the shared MAC; valid while busy=1.
REQ-009 shift_en0 / shift_en1  output  1 each  delay-line shift enable for channel 0 / 1.
REQ-010 acc_clr  output  1  clear shared accumulator.
REQ-011 acc_en  output  1  accumulate product this cycle.
REQ-012 tap_idx  output  TAP_W  delay-line and coefficient tap select.
REQ-013 oe0 / oe1  output  1 each  output-register load strobe for channel 0 / 1.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 ovr0 / ovr1  output  1 each  sticky overrun flag for channel 0 / 1.

Function
REQ-016 FSM states are IDLE, SHIFT, MAC and DONE; all outputs are registered state decodes.
REQ-017 Each channel has a pending bit, set at the clock edge where sample_i=1.
REQ-018 In IDLE or DONE, any pending channel is granted: the next state is SHIFT, ch_sel takes the granted channel, and that channel's pending bit clears.
REQ-019 If both channels are pending, arbitration is round-robin: the channel not granted last wins; after reset channel 0 wins first.
REQ-020 In SHIFT (1 cycle): shift_en for ch_sel=1, acc_clr=1, acc_en=0.
REQ-021 In MAC (NTAPS cycles): acc_en=1, and tap_idx counts 0..NTAPS-1, incrementing by 1 per cycle.
REQ-022 tap_idx=NTAPS-1 in MAC gives next state DONE; the counter wraps to 0.
REQ-023 In DONE (1 cycle): oe for ch_sel=1, acc_en=0.
REQ-024 Leaving DONE, the FSM goes to SHIFT if any channel is pending, else to IDLE.
REQ-025 Service latency for an uncontended sample strobed in cycle N:
  - SHIFT in cycle N+1;
  - MAC in cycles N+2..N+NTAPS+1;
  - oe in cycle N+NTAPS+2.
REQ-026 Back-to-back services have NTAPS+2 cycles per output; there is no IDLE gap between them.
REQ-027 Overrun: sample_i=1 while pending_i is already 1 and not being granted that edge.
  - ovr_i sets to 1 and the strobe is dropped.
  - pending_i stays 1.
REQ-028 A sample_i at the same edge as the grant of channel i leaves pending_i=1 and does not set ovr_i.
REQ-029 A sample for the channel currently in MAC is legal and only sets its pending bit.
REQ-030 ovr_clr=1 clears ovr0 and ovr1; simultaneous ovr_clr and a new overrun leaves the flag set.
REQ-031 At most one of shift_en0, shift_en1, oe0 and oe1 is high in any cycle.
REQ-032 acc_en and acc_clr are never both high.
REQ-033 When busy=0: tap_idx=0, ch_sel=0, and all strobes are 0.

Reset
REQ-034 While reset=1: state IDLE, pending bits 0, ovr flags 0, tap_idx 0, all strobes 0, busy 0, round-robin pointer set so channel 0 wins next.
REQ-035 Reset mid-service aborts the service with no oe pulse, and strobes arriving in a reset cycle are discarded.
REQ-036 The first grant can occur on the edge after reset deasserts.

Structure
REQ-037 Package fir_sched_pkg holds the state enumeration, NTAPS and TAP_W defaults, and the channel-index type.
REQ-038 The tap counter is one sub-module, fir_tap_counter, with enable, synchronous clear, a TAP_W-bit count and a terminal-count output.
REQ-039 The arbiter and pending/overrun logic stay in the top module.

Verification
REQ-040 Single sample: sample0 at cycle 10 -> shift_en0 at 11; acc_en at 12..43 with tap_idx 0..31; oe0 at 44; busy=0 at 45.
REQ-041 Simultaneous sample0 and sample1 at cycle 10, just after reset:
  - channel 0 is served first, with oe0 at 44;
  - channel 1 goes to SHIFT at 45 and gets oe1 at 78;
  - no overrun.
REQ-042 Round-robin: both channels pending again during the channel-1 service -> channel 0 is granted next, then channel 1, alternating.
REQ-043 Overrun: sample1 at 10 and 20 while channel 0 is busy from cycle 5 -> ovr1=1 from 21, one channel-1 service only; ovr_clr at 100 -> ovr1=0 at 101.
REQ-044 Reset at cycle 30 during MAC -> all outputs 0 from 31, no oe, and a new sample0 at 35 is served with oe0 at 69.
REQ-045 Continuous sample0 every 34 cycles -> zero overruns, and the oe0 period is 34 cycles.
